// File: rtl/mem_rw_arbiter.sv
// Round-robin arbiter sharing one memory_controller read/write port among NUM_CH masters.
// Latency: grant -> mem_rw valid next cycle; mem_vld -> ch_vld next cycle; 3 cycles minimum per transaction.
// Backpressure: requesters hold their command until ch_vld; a silent memory is cut off after TIMEOUT cycles with ch_err.
module mem_rw_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*NUM_CH-1:0]      ch_rw,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wr_data,
    output logic [NUM_CH-1:0]        ch_vld,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        ch_rd_data,
    output logic [1:0]               mem_rw,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wr_data,
    input  logic [DATA_W-1:0]        mem_rd_data,
    input  logic                     mem_vld
);

    localparam int GW = $clog2(NUM_CH);
    // A zero TIMEOUT still needs a legal (unused) counter width.
    localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant;
    logic [GW-1:0] pick;
    logic          pick_vld;
    logic [CW-1:0] cnt;
    logic [CW:0]   cnt_inc;
    logic          tmo_hit;

    // Rotating priority: first requester after last_grant wins (lowest offset assigned last).
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = NUM_CH; k >= 1; k--) begin
            if (ch_rw[2*((int'(last_grant) + k) % NUM_CH) + 1]) begin
                pick     = GW'((int'(last_grant) + k) % NUM_CH);
                pick_vld = 1'b1;
            end
        end
    end

    // Timeout fires on the BUSY cycle whose increment would make the counter equal TIMEOUT.
    always_comb begin
        cnt_inc = {1'b0, cnt} + 1'b1;
        tmo_hit = (TIMEOUT != 0) && (cnt_inc == (CW+1)'(TIMEOUT));
    end

    // Arbiter FSM; every output is a register updated here. mem_rw[0] doubles as the latched op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= GW'(NUM_CH - 1);
            grant       <= '0;
            cnt         <= '0;
            mem_rw      <= 2'b00;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            ch_vld      <= '0;
            ch_err      <= '0;
            ch_rd_data  <= '0;
        end else begin
            ch_vld <= '0;
            ch_err <= '0;
            case (state)
                IDLE: begin
                    // mem_vld is deliberately ignored here.
                    if (pick_vld) begin
                        grant       <= pick;
                        mem_rw      <= {1'b1, ch_rw[2*int'(pick)]};
                        mem_addr    <= ch_addr[int'(pick)*ADDR_W +: ADDR_W];
                        mem_wr_data <= ch_wr_data[int'(pick)*DATA_W +: DATA_W];
                        cnt         <= '0;
                        state       <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_vld) begin
                        mem_rw        <= 2'b00;
                        ch_vld[grant] <= 1'b1;
                        if (mem_rw[0]) begin
                            ch_rd_data <= mem_rd_data;
                        end
                        state <= RESP;
                    end else if (tmo_hit) begin
                        mem_rw        <= 2'b00;
                        ch_vld[grant] <= 1'b1;
                        ch_err[grant] <= 1'b1;
                        ch_rd_data    <= '0;
                        state         <= RESP;
                    end else if (cnt != {CW{1'b1}}) begin
                        cnt <= cnt_inc[CW-1:0];
                    end
                end
                RESP: begin
                    last_grant <= grant;
                    cnt        <= '0;
                    state      <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    mem_rw <= 2'b00;
                end
            endcase
        end
    end

endmodule
